pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. It decides, every cycle, whether the PC advances, what the IF/ID register captures (held instruction, NOP, or fetched instruction), and whether ID/EX is bubbled or the back end frozen. It resolves load-use hazards, taken-branch redirects, instruction-fetch wait and data-memory busy, and keeps stall/flush performance counters.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, performance-counter width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous, active-low reset.
- id_rs1_i  in  REG_AW  rs1 of the instruction in ID.
- id_rs2_i  in  REG_AW  rs2 of the instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_rd_i  in  REG_AW  rd of the instruction in EX.
- ex_mem_read_i  in  1  EX instruction is a load.
- ex_branch_taken_i  in  1  EX resolved a taken branch or jump.
- imem_valid_i  in  1  fetched instruction is valid this cycle.
- dmem_busy_i  in  1  data memory is not done this cycle.
- pc_we_o  out  1  PC register load enable.
- pc_sel_o  out  1  1 = load branch target, 0 = PC+4.
- ifid_sel_o  out  2  IF/ID mux select: 0 = HOLD (re-capture current instr), 1 = NOP, 2 = PASS.
- idex_flush_o  out  1  ID/EX captures a bubble.
- back_we_o  out  1  enable for ID/EX, EX/MEM, MEM/WB.
- stall_cnt_o  out  CNT_W  cycles with pc_we_o = 0.
- flush_cnt_o  out  CNT_W  number of redirects taken.

## Operation
- States: RUN, REFETCH, FREEZE. Reset state REFETCH.
- Control outputs are Mealy (state + current inputs). Priority when conditions coincide: dmem_busy > branch redirect > load-use > fetch wait.
- FREEZE entered from any state when dmem_busy_i = 1: pc_we=0, ifid_sel=HOLD, idex_flush=0, back_we=0. The state before freezing is saved. The block leaves FREEZE in the first cycle with dmem_busy_i = 0 and behaves as the saved state in that same cycle. A branch or load-use seen during FREEZE is not acted on until release.
- Redirect (RUN or REFETCH, ex_branch_taken_i = 1, not busy): pc_we=1, pc_sel=1, ifid_sel=NOP, idex_flush=1, back_we=1; flush_cnt += 1; next state REFETCH.
- Load-use (RUN, ex_mem_read_i and ex_rd_i != 0 and ((rs1_used and rs1 == ex_rd) or (rs2_used and rs2 == ex_rd))): pc_we=0, ifid_sel=HOLD, idex_flush=1, back_we=1. Stay in RUN. This lasts exactly one cycle because the load advances to MEM.
- REFETCH: ifid_sel=NOP, idex_flush=0, back_we=1, and pc_we = imem_valid_i. The state moves to RUN when imem_valid_i = 1. That cycle still inserts NOP, because the first valid instruction is captured in the following RUN cycle.
- RUN with no event: if imem_valid_i = 1, then pc_we=1, pc_sel=0, ifid_sel=PASS, idex_flush=0, back_we=1. If imem_valid_i = 0, then pc_we=0, ifid_sel=NOP, and ID drains.
- pc_sel_o = 0 whenever no redirect is active.
- Counters: stall_cnt increments every cycle with pc_we_o = 0, reset excluded. Both counters wrap modulo 2^CNT_W.
- A register match on x0 never stalls.

## Timing
- Asynchronous reset: state = REFETCH, saved state = REFETCH, counters = 0. While rst_ni = 0, outputs are pc_we=0, pc_sel=0, ifid_sel=NOP(1), idex_flush=1, back_we=0.
- Reset deassertion mid-FREEZE or mid-REFETCH always restarts in REFETCH. No pending state survives.
- Decision latency is 0 cycles: outputs react combinationally to this cycle's inputs and are sampled by the stage registers at the same posedge. State and counters update on the posedge.
- Branch penalty is 2 cycles after the redirect cycle, plus any imem wait.
- When a branch and a load-use occur in the same cycle, the redirect wins: the load-use instruction in ID is flushed and no HOLD is issued.

## Test plan
- Reset release with imem_valid_i = 1 constant: cycle 0 is REFETCH (ifid_sel=1, pc_we=1), cycle 1 is RUN (ifid_sel=2). stall_cnt = 0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, rs2_used=1 -> one cycle with pc_we=0, ifid_sel=0, idex_flush=1. stall_cnt +1. Repeat with ex_rd=0 -> no stall.
- Taken branch in RUN -> pc_sel=1, ifid_sel=1, idex_flush=1, flush_cnt=1. Next cycle REFETCH with ifid_sel=1, then PASS.
- dmem_busy_i high for 3 cycles while a branch is pending -> 3 cycles with back_we=0 and ifid_sel=0. The redirect is issued in the release cycle. stall_cnt +3.
- imem_valid_i low for 4 cycles in RUN -> pc_we=0 and ifid_sel=1 for 4 cycles. stall_cnt +4.
- Branch coinciding with a load-use match -> redirect outputs only (ifid_sel=1, pc_we=1).

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC advance, IF/ID select, ID/EX bubble, back-end freeze.
// Resolves load-use, redirects, fetch wait and dmem busy; keeps perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_branch_taken_i,
  input  logic              imem_valid_i,
  input  logic              dmem_busy_i,
  output logic              pc_we_o,
  output logic              pc_sel_o,
  output logic [1:0]        ifid_sel_o,
  output logic              idex_flush_o,
  output logic              back_we_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    REFETCH = 2'd1,
    FREEZE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_NOP  = 2'd1;
  localparam logic [1:0] SEL_PASS = 2'd2;

  state_t state, state_nx;
  state_t saved, saved_nx;
  state_t eff;

  logic rs1_hit, rs2_hit, lu_hit;
  logic c_rst, c_frz, c_redir, c_lu, c_refetch, c_run;

  assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);
  assign lu_hit  = ex_mem_read_i && (ex_rd_i != '0)
                 && (rs1_hit || rs2_hit);

  // on release from FREEZE, act as the state that was frozen
  assign eff = (state == FREEZE) ? saved : state;

  assign c_rst     = !rst_ni;
  assign c_frz     = rst_ni && dmem_busy_i;
  assign c_redir   = rst_ni && !dmem_busy_i && ex_branch_taken_i;
  assign c_lu      = rst_ni && !dmem_busy_i && !ex_branch_taken_i
                   && (eff == RUN) && lu_hit;
  assign c_refetch = rst_ni && !dmem_busy_i && !ex_branch_taken_i
                   && (eff == REFETCH);
  assign c_run     = rst_ni && !dmem_busy_i && !ex_branch_taken_i
                   && (eff == RUN) && !lu_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= REFETCH;
      saved <= REFETCH;
    end else begin
      state <= state_nx;
      saved <= saved_nx;
    end
  end

  always_comb begin
    state_nx = state;
    saved_nx = saved;
    if (dmem_busy_i) begin
      state_nx = FREEZE;
      if (state != FREEZE) saved_nx = state;
    end else if (ex_branch_taken_i) begin
      state_nx = REFETCH;
    end else begin
      unique case (eff)
        REFETCH: state_nx = imem_valid_i ? RUN : REFETCH;
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    pc_we_o      = 1'b0;
    pc_sel_o     = 1'b0;
    ifid_sel_o   = SEL_NOP;
    idex_flush_o = 1'b0;
    back_we_o    = 1'b1;
    unique case (1'b1)
      c_rst: begin
        idex_flush_o = 1'b1;
        back_we_o    = 1'b0;
      end
      c_frz: begin
        ifid_sel_o = SEL_HOLD;
        back_we_o  = 1'b0;
      end
      c_redir: begin
        pc_we_o      = 1'b1;
        pc_sel_o     = 1'b1;
        idex_flush_o = 1'b1;
      end
      c_lu: begin
        ifid_sel_o   = SEL_HOLD;
        idex_flush_o = 1'b1;
      end
      c_refetch: begin
        pc_we_o = imem_valid_i;
      end
      c_run: begin
        pc_we_o    = imem_valid_i;
        ifid_sel_o = imem_valid_i ? SEL_PASS : SEL_NOP;
      end
      default: begin
        pc_we_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_we_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (c_redir)  flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Inputs change on negedge; outputs checked 1ns later.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        rs1_used, rs2_used, mem_read, br;
  logic        imem_valid, dmem_busy;
  logic        pc_we, pc_sel, idex_flush, back_we;
  logic [1:0]  ifid_sel;
  logic [31:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .id_rs1_i          (rs1),
    .id_rs2_i          (rs2),
    .id_rs1_used_i     (rs1_used),
    .id_rs2_used_i     (rs2_used),
    .ex_rd_i           (rd),
    .ex_mem_read_i     (mem_read),
    .ex_branch_taken_i (br),
    .imem_valid_i      (imem_valid),
    .dmem_busy_i       (dmem_busy),
    .pc_we_o           (pc_we),
    .pc_sel_o          (pc_sel),
    .ifid_sel_o        (ifid_sel),
    .idex_flush_o      (idex_flush),
    .back_we_o         (back_we),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic we, input logic sel,
                      input logic [1:0] ifid, input logic fl,
                      input logic bw);
    chk({tag, ".pc_we"}, 32'(pc_we), 32'(we));
    chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(sel));
    chk({tag, ".ifid"}, 32'(ifid_sel), 32'(ifid));
    chk({tag, ".flush"}, 32'(idex_flush), 32'(fl));
    chk({tag, ".back_we"}, 32'(back_we), 32'(bw));
  endtask

  task automatic quiet();
    rs1 = '0; rs2 = '0; rd = '0;
    rs1_used = 0; rs2_used = 0; mem_read = 0; br = 0;
    dmem_busy = 0; imem_valid = 1;
  endtask

  task automatic nxt();
    @(negedge clk);
    quiet();
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    repeat (3) @(negedge clk);
    #1;
    outs("rst", 0, 0, 1, 1, 0);
    chk("rst.stall", stall_cnt, 0);
    chk("rst.flush_cnt", flush_cnt, 0);

    // c0: REFETCH after release
    @(negedge clk); quiet(); rst_n = 1'b1; #1;
    outs("c0", 1, 0, 1, 0, 1);
    chk("c0.stall", stall_cnt, 0);
    nxt(); #1;
    outs("c1", 1, 0, 2, 0, 1);

    // load-use on rs2
    nxt(); mem_read = 1; rd = 5; rs2 = 5; rs2_used = 1; #1;
    outs("lu_rs2", 0, 0, 0, 1, 1);
    nxt(); #1;
    outs("c3", 1, 0, 2, 0, 1);
    chk("c3.stall", stall_cnt, 1);

    // x0 match must not stall
    nxt(); mem_read = 1; rd = 0; rs2 = 0; rs2_used = 1; #1;
    outs("x0", 1, 0, 2, 0, 1);

    // load-use on rs1
    nxt(); mem_read = 1; rd = 7; rs1 = 7; rs1_used = 1; #1;
    outs("lu_rs1", 0, 0, 0, 1, 1);

    // match on unused rs1 does not stall
    nxt(); mem_read = 1; rd = 7; rs1 = 7; rs2 = 3; rs2_used = 1; #1;
    outs("unused", 1, 0, 2, 0, 1);
    chk("c6.stall", stall_cnt, 2);

    // taken branch in RUN
    nxt(); br = 1; #1;
    outs("br", 1, 1, 1, 1, 1);
    nxt(); #1;
    outs("br_refetch", 1, 0, 1, 0, 1);
    chk("br.flush_cnt", flush_cnt, 1);
    nxt(); #1;
    outs("br_pass", 1, 0, 2, 0, 1);

    // busy for 3 cycles with a branch pending
    for (int i = 0; i < 3; i++) begin
      nxt(); dmem_busy = 1; br = 1; #1;
      outs($sformatf("frz%0d", i), 0, 0, 0, 0, 0);
    end
    nxt(); br = 1; #1;
    outs("release", 1, 1, 1, 1, 1);
    chk("frz.stall", stall_cnt, 5);
    nxt(); #1;
    outs("rel_refetch", 1, 0, 1, 0, 1);
    chk("rel.flush_cnt", flush_cnt, 2);
    nxt(); #1;
    outs("rel_pass", 1, 0, 2, 0, 1);

    // fetch wait in RUN
    for (int i = 0; i < 4; i++) begin
      nxt(); imem_valid = 0; #1;
      outs($sformatf("iw%0d", i), 0, 0, 1, 0, 1);
    end
    nxt(); #1;
    outs("iw_done", 1, 0, 2, 0, 1);
    chk("iw.stall", stall_cnt, 9);

    // branch coinciding with load-use
    nxt(); br = 1; mem_read = 1; rd = 4; rs1 = 4; rs1_used = 1; #1;
    outs("br_lu", 1, 1, 1, 1, 1);

    // REFETCH waiting on imem, then frozen, then released
    nxt(); imem_valid = 0; #1;
    outs("rf_wait", 0, 0, 1, 0, 1);
    nxt(); dmem_busy = 1; #1;
    outs("rf_frz", 0, 0, 0, 0, 0);
    nxt(); mem_read = 1; rd = 4; rs1 = 4; rs1_used = 1; #1;
    outs("rf_rel", 1, 0, 1, 0, 1);
    chk("rf.stall", stall_cnt, 11);
    chk("rf.flush_cnt", flush_cnt, 3);
    nxt(); #1;
    outs("rf_pass", 1, 0, 2, 0, 1);

    // reset asserted mid-FREEZE restarts in REFETCH
    nxt(); dmem_busy = 1; #1;
    outs("pre_rst", 0, 0, 0, 0, 0);
    nxt(); dmem_busy = 1; rst_n = 1'b0; #1;
    outs("rst2", 0, 0, 1, 1, 0);
    chk("rst2.stall", stall_cnt, 0);
    chk("rst2.flush_cnt", flush_cnt, 0);
    nxt(); rst_n = 1'b1; #1;
    outs("rst2_rf", 1, 0, 1, 0, 1);
    nxt(); #1;
    outs("rst2_pass", 1, 0, 2, 0, 1);
    chk("rst2_pass.stall", stall_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
